// File: rtl/block_generate_wb_burst_master.sv
// Wishbone burst write master producing counter/PRBS test blocks for the block-check slave.
// Optional master stall insertion is enabled by defining GEN_WB_BURST_STALL_EN.
`timescale 1ns/1ps
module block_generate_wb_burst_master #(
    parameter int unsigned BURST_LEN    = 512,
    parameter int unsigned STALL_PERIOD = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [11:0] ov_wbm_burst_addr,
    output logic [63:0] ov_wbm_burst_data,
    output logic [7:0]  ov_wbm_burst_sel,
    output logic        o_wbm_burst_we,
    output logic        o_wbm_burst_cyc,
    output logic        o_wbm_burst_stb,
    output logic [2:0]  ov_wbm_burst_cti,
    output logic [1:0]  ov_wbm_burst_bte,
    input  logic        i_wbm_burst_ack,
    input  logic        i_wbm_burst_err,
    input  logic        i_wbm_burst_rty,
    input  logic [15:0] iv_control,
    output logic [31:0] ov_block_cnt,
    output logic        o_gen_busy,
    output logic        o_gen_err
);
    localparam int unsigned     BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [2:0]      CTI_INC   = 3'b001;
    localparam logic [2:0]      CTI_END   = 3'b111;
`ifdef GEN_WB_BURST_STALL_EN
    localparam int unsigned     STALL_W   = $clog2(STALL_PERIOD + 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_HALT} state_t;

    state_t             r_state;
    logic [BEAT_W-1:0]  r_beat;
    logic [63:0]        r_cnt_pat;
    logic [63:0]        r_prbs;
    logic [63:0]        r_data;
    logic               r_pat_prbs;
    logic               r_need_rearm;
    logic               r_cyc;
    logic               r_stb;
    logic               r_busy;
    logic               r_err;
    logic [2:0]         r_cti;
    logic [31:0]        r_block_cnt;
`ifdef GEN_WB_BURST_STALL_EN
    logic [STALL_W-1:0] r_stall_cnt;
`endif

    logic               w_run;
    logic               w_pat;
    logic               w_single;
    logic               w_clear;
    logic               w_accept;
    logic               w_last;
    logic [BEAT_W-1:0]  w_beat_next;
    logic [63:0]        w_cnt_next;
    logic [63:0]        w_prbs_next;
    logic               w_unused;

    assign w_run       = iv_control[0];
    assign w_pat       = iv_control[1];
    assign w_single    = iv_control[2];
    assign w_clear     = iv_control[3];
    assign w_accept    = r_cyc & r_stb & i_wbm_burst_ack;
    assign w_last      = (r_beat == LAST_BEAT);
    assign w_beat_next = r_beat + BEAT_W'(1);
    assign w_cnt_next  = r_cnt_pat + 64'd1;
    // Fibonacci LFSR, taps 64,63,61,60
    assign w_prbs_next = {r_prbs[62:0], r_prbs[63] ^ r_prbs[62] ^ r_prbs[60] ^ r_prbs[59]};
    assign w_unused    = ^{i_wbm_burst_rty, iv_control[15:4], (STALL_PERIOD != 0)};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_cnt_pat    <= '0;
            r_prbs       <= 64'h1;
            r_data       <= '0;
            r_pat_prbs   <= 1'b0;
            r_need_rearm <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_cti        <= CTI_INC;
            r_block_cnt  <= '0;
`ifdef GEN_WB_BURST_STALL_EN
            r_stall_cnt  <= '0;
`endif
        end else if (i_wbm_burst_err) begin
            // Abort: the partial block is dropped and not counted
            r_state     <= S_HALT;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b1;
            r_beat      <= '0;
            r_cti       <= CTI_INC;
`ifdef GEN_WB_BURST_STALL_EN
            r_stall_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_run) begin
                        r_need_rearm <= 1'b0;
                    end
                    if (w_clear) begin
                        r_block_cnt <= '0;
                        r_cnt_pat   <= '0;
                        r_prbs      <= 64'h1;   // all-zero would lock the LFSR, so reseed
                    end else if (w_run && !r_err && !r_need_rearm) begin
                        r_state    <= S_BURST;
                        r_cyc      <= 1'b1;
                        r_stb      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_pat_prbs <= w_pat;
                        r_data     <= w_pat ? r_prbs : r_cnt_pat;
                    end
                end
                S_BURST: begin
                    if (w_accept) begin
                        if (r_pat_prbs) begin
                            r_prbs <= w_prbs_next;
                            r_data <= w_prbs_next;
                        end else begin
                            r_cnt_pat <= w_cnt_next;
                            r_data    <= w_cnt_next;
                        end
                        if (w_last) begin
                            r_beat      <= '0;
                            r_cti       <= CTI_INC;
                            r_block_cnt <= r_block_cnt + 32'd1;
                            r_state     <= S_GAP;
                            r_cyc       <= 1'b0;
                            r_stb       <= 1'b0;
`ifdef GEN_WB_BURST_STALL_EN
                            r_stall_cnt <= '0;
`endif
                        end else begin
                            r_beat <= w_beat_next;
                            r_cti  <= (w_beat_next == LAST_BEAT) ? CTI_END : CTI_INC;
`ifdef GEN_WB_BURST_STALL_EN
                            if (r_stall_cnt == STALL_W'(STALL_PERIOD - 1)) begin
                                r_stall_cnt <= '0;
                                r_stb       <= 1'b0;
                            end else begin
                                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                            end
`endif
                        end
                    end
`ifdef GEN_WB_BURST_STALL_EN
                    else if (!r_stb) begin
                        r_stb <= 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (w_single || !w_run) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_need_rearm <= w_single;
                    end else begin
                        r_state <= S_BURST;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (w_clear) begin
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ov_wbm_burst_addr = 12'h000;
    assign ov_wbm_burst_sel  = 8'hFF;
    assign ov_wbm_burst_bte  = 2'b00;
    assign o_wbm_burst_we    = r_cyc;
    assign o_wbm_burst_cyc   = r_cyc;
    assign o_wbm_burst_stb   = r_stb;
    assign ov_wbm_burst_cti  = r_cti;
    assign ov_wbm_burst_data = r_data;
    assign ov_block_cnt      = r_block_cnt;
    assign o_gen_busy        = r_busy;
    assign o_gen_err         = r_err;

endmodule

// File: tb/tb_block_generate_wb_burst_master.sv
// Directed bench for block_generate_wb_burst_master: counter/PRBS blocks, wait states, err/halt, reset.
`timescale 1ns/1ps
module tb_block_generate_wb_burst_master;
    localparam int unsigned LEN = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err_in;
    logic        rty_in;
    logic [15:0] control;
    logic [31:0] block_cnt;
    logic        busy, gen_err;

    logic        ack_en;
    logic        ack_force;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_cycles;
    int          beat_idx;
    logic [63:0] exp_cnt;
    logic [63:0] exp_prbs;
    bit          exp_mode_prbs;
    logic [63:0] prbs_hand [4] = '{64'h1, 64'h2, 64'h4, 64'h8};

    always #5 clk = ~clk;

    assign ack = ack_force | (cyc & stb & ack_en);

    block_generate_wb_burst_master #(.BURST_LEN(LEN), .STALL_PERIOD(16)) u_dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .ov_wbm_burst_addr (addr),
        .ov_wbm_burst_data (data),
        .ov_wbm_burst_sel  (sel),
        .o_wbm_burst_we    (we),
        .o_wbm_burst_cyc   (cyc),
        .o_wbm_burst_stb   (stb),
        .ov_wbm_burst_cti  (cti),
        .ov_wbm_burst_bte  (bte),
        .i_wbm_burst_ack   (ack),
        .i_wbm_burst_err   (err_in),
        .i_wbm_burst_rty   (rty_in),
        .iv_control        (control),
        .ov_block_cnt      (block_cnt),
        .o_gen_busy        (busy),
        .o_gen_err         (gen_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    function automatic logic [63:0] exp_data();
        return exp_mode_prbs ? exp_prbs : exp_cnt;
    endfunction

    task automatic advance_model();
        if (exp_mode_prbs) exp_prbs = lfsr_step(exp_prbs);
        else               exp_cnt  = exp_cnt + 64'd1;
        beat_idx = (beat_idx == LEN - 1) ? 0 : beat_idx + 1;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_cyc"},  64'(cyc),       64'd0);
        check_eq({tag, "_stb"},  64'(stb),       64'd0);
        check_eq({tag, "_we"},   64'(we),        64'd0);
        check_eq({tag, "_addr"}, 64'(addr),      64'd0);
        check_eq({tag, "_sel"},  64'(sel),       64'hFF);
        check_eq({tag, "_bte"},  64'(bte),       64'd0);
        check_eq({tag, "_cti"},  64'(cti),       64'd1);
        check_eq({tag, "_data"}, data,           64'd0);
        check_eq({tag, "_bcnt"}, 64'(block_cnt), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy),      64'd0);
        check_eq({tag, "_err"},  64'(gen_err),   64'd0);
    endtask

    // Consumes n accepted beats from the current negedge, checking data and cti of each
    task automatic take_beats(input int n, input int stall_at, input int stall_len);
        int got = 0;
        int guard = 0;
        while (got < n && guard < 4000) begin
            if (cyc) cyc_cycles++;
            if (cyc && stb) begin
                if (got == stall_at) begin
                    ack_en = 1'b0;
                    repeat (stall_len) begin
                        @(negedge clk);
                        check_eq("wait_data_hold", data, exp_data());
                        check_eq("wait_cyc_hold", 64'(cyc), 64'd1);
                        check_eq("wait_cti_hold", 64'(cti), 64'd1);
                    end
                    ack_en = 1'b1;
                end
                check_eq("beat_data", data, exp_data());
                check_eq("beat_cti", 64'(cti), (beat_idx == LEN - 1) ? 64'd7 : 64'd1);
                advance_model();
                got++;
            end
            @(negedge clk);
            guard++;
        end
        check_eq("beats_taken", 64'(got), 64'(n));
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; control = '0; ack_en = 1'b1; ack_force = 1'b0;
        err_in = 1'b0; rty_in = 1'b0;
        exp_cnt = '0; exp_prbs = 64'h1; exp_mode_prbs = 1'b0; beat_idx = 0; cyc_cycles = 0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_no_run_cyc", 64'(cyc), 64'd0);

        // Single counter block
        control = 16'h0005;
        @(negedge clk);
        check_eq("start_latency_cyc", 64'(cyc), 64'd1);
        check_eq("start_busy", 64'(busy), 64'd1);
        take_beats(LEN, -1, 0);
        check_eq("single_gap_cyc", 64'(cyc), 64'd0);
        check_eq("single_bcnt", 64'(block_cnt), 64'd1);
        @(negedge clk);
        check_eq("single_idle_busy", 64'(busy), 64'd0);
        ack_force = 1'b1; rty_in = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("single_no_rearm_cyc", 64'(cyc), 64'd0);
        check_eq("stray_ack_data", data, exp_cnt);
        ack_force = 1'b0; rty_in = 1'b0;

        // Continuous counter blocks; run dropped mid third block
        control = 16'h0000;
        @(negedge clk);
        control = 16'h0001;
        @(negedge clk);
        check_eq("cont_start_cyc", 64'(cyc), 64'd1);
        check_eq("cont_first_data", data, 64'd512);
        take_beats(LEN, -1, 0);
        check_eq("cont_gap1_cyc", 64'(cyc), 64'd0);
        @(negedge clk);
        check_eq("cont_gap1_end_cyc", 64'(cyc), 64'd1);
        take_beats(LEN, -1, 0);
        check_eq("cont_gap2_cyc", 64'(cyc), 64'd0);
        @(negedge clk);
        check_eq("cont_gap2_end_cyc", 64'(cyc), 64'd1);
        take_beats(200, -1, 0);
        control = 16'h0000;
        take_beats(LEN - 200, -1, 0);
        check_eq("cont_end_cyc", 64'(cyc), 64'd0);
        check_eq("cont_bcnt", 64'(block_cnt), 64'd4);
        @(negedge clk);
        check_eq("cont_idle_busy", 64'(busy), 64'd0);
        check_eq("cont_idle_cyc", 64'(cyc), 64'd0);

        // Clear in IDLE
        control = 16'h0008;
        @(negedge clk);
        control = 16'h0000;
        check_eq("clear_bcnt", 64'(block_cnt), 64'd0);
        exp_cnt = '0; exp_prbs = 64'h1;

        // PRBS single block with wait states; pattern bit flipped mid-block
        control = 16'h0007;
        exp_mode_prbs = 1'b1;
        beat_idx = 0;
        @(negedge clk);
        check_eq("prbs_start_cyc", 64'(cyc), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("prbs_hand_seq", data, prbs_hand[i]);
            advance_model();
            @(negedge clk);
        end
        take_beats(96, 6, 5);
        control = 16'h0005;
        take_beats(LEN - 100, -1, 0);
        check_eq("prbs_bcnt", 64'(block_cnt), 64'd1);
        @(negedge clk);
        check_eq("prbs_idle_busy", 64'(busy), 64'd0);

        // Slave error after beat 100, halt, clear, resume
        control = 16'h0000;
        @(negedge clk);
        control = 16'h0001;
        exp_mode_prbs = 1'b0;
        beat_idx = 0;
        @(negedge clk);
        take_beats(101, -1, 0);
        err_in = 1'b1; ack_en = 1'b0;
        @(negedge clk);
        err_in = 1'b0; ack_en = 1'b1;
        check_eq("err_cyc_drop", 64'(cyc), 64'd0);
        check_eq("err_stb_drop", 64'(stb), 64'd0);
        check_eq("err_flag", 64'(gen_err), 64'd1);
        check_eq("err_bcnt_kept", 64'(block_cnt), 64'd1);
        repeat (3) @(negedge clk);
        check_eq("halt_hold_cyc", 64'(cyc), 64'd0);
        check_eq("halt_hold_busy", 64'(busy), 64'd1);
        control = 16'h0009;
        @(negedge clk);
        check_eq("halt_clear_err", 64'(gen_err), 64'd0);
        check_eq("halt_clear_busy", 64'(busy), 64'd0);
        control = 16'h0005;
        beat_idx = 0;
        @(negedge clk);
        check_eq("resume_cyc", 64'(cyc), 64'd1);
        check_eq("resume_data", data, 64'd101);
        take_beats(LEN, -1, 0);
        check_eq("resume_bcnt", 64'(block_cnt), 64'd2);
        @(negedge clk);

`ifdef GEN_WB_BURST_STALL_EN
        control = 16'h0000;
        @(negedge clk);
        control = 16'h0005;
        beat_idx = 0;
        @(negedge clk);
        cyc_cycles = 0;
        take_beats(LEN, -1, 0);
        check_eq("stall_cyc_cycles", 64'(cyc_cycles), 64'(LEN + 31));
        @(negedge clk);
`endif

        // Asynchronous reset in the middle of a block
        control = 16'h0000;
        @(negedge clk);
        control = 16'h0001;
        beat_idx = 0;
        @(negedge clk);
        take_beats(300, -1, 0);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_cyc", 64'(cyc), 64'd0);
        check_eq("async_rst_stb", 64'(stb), 64'd0);
        @(negedge clk);
        check_reset("midrst");
        rst_n = 1'b1;
        exp_cnt = '0; exp_prbs = 64'h1; beat_idx = 0;
        @(negedge clk);
        check_eq("post_rst_cyc", 64'(cyc), 64'd1);
        take_beats(5, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_generate_wb_burst_master.md
# block_generate_wb_burst_master

Wishbone burst write master that generates DS_DMA test-check traffic and feeds the block-check burst slave directly downstream. It issues back-to-back 512-beat, 64-bit, constant-address write bursts carrying an incrementing-counter or PRBS pattern. It counts completed blocks and halts on a slave error until software clears it through the WBS_CFG control word.

## Interface
- BURST_LEN, 512, beats per block (2..512)
- STALL_PERIOD, 16, acked beats between inserted master stalls (used only with the macro)

- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- ov_wbm_burst_addr  out  12  burst address; constant 0
- ov_wbm_burst_data  out  64  write data
- ov_wbm_burst_sel  out  8  byte select; constant 8'hFF
- o_wbm_burst_we  out  1  write enable; 1 whenever cyc=1
- o_wbm_burst_cyc  out  1  WB cycle
- o_wbm_burst_stb  out  1  WB strobe
- ov_wbm_burst_cti  out  3  3'b001 for beats 0..BURST_LEN-2, 3'b111 for last beat
- ov_wbm_burst_bte  out  2  constant 2'b00
- i_wbm_burst_ack  in  1  slave ack (may be combinational from stb)
- i_wbm_burst_err  in  1  slave error (registered by slave, one cycle after the offending beat)
- i_wbm_burst_rty  in  1  ignored
- iv_control  in  16  [0] run, [1] pattern (0=counter, 1=PRBS), [2] single block, [3] clear; [15:4] reserved
- ov_block_cnt  out  32  completed blocks, wraps at 2^32
- o_gen_busy  out  1  1 while FSM is not IDLE
- o_gen_err  out  1  sticky slave-error flag

## Operation
- Reset values (asynchronous on i_rst_n=0): cyc=stb=we=0, addr=0, sel=8'hFF, bte=0, cti=3'b001, data=0, ov_block_cnt=0, o_gen_busy=0, o_gen_err=0, FSM=IDLE, beat counter=0.
- Reset also sets the PRBS register to 64'h1 and the counter pattern to 0.
- Beat accepted = cyc & stb & ack in the same cycle. Data, beat counter and cti update on the next edge.
- Counter pattern: data = 64-bit value, incremented per accepted beat. It continues across blocks and wraps at 2^64.
- PRBS pattern: 64-bit Fibonacci LFSR, taps 64,63,61,60. It advances per accepted beat.
- The pattern bit is sampled only in IDLE; changes mid-block are ignored until the next block.
- FSM:
  - IDLE: run=1 and o_gen_err=0 → BURST.
  - BURST: cyc=stb=1. On accepted last beat: ov_block_cnt+1, beat counter cleared → GAP.
  - GAP: one cycle with cyc=stb=0. Then: single=1 or run=0 → IDLE; otherwise → BURST.
  - HALT: cyc=stb=0, holds. Clear=1 → o_gen_err=0 → IDLE.
  - i_wbm_burst_err=1 in any state → o_gen_err=1, cyc/stb dropped next edge → HALT. A partial block is not counted.
- Run deasserted mid-block: the current block completes (no truncation), then IDLE.
- Single-block mode needs run to be deasserted and reasserted before a new block.
- Clear (bit 3) outside HALT: zeroes ov_block_cnt and the pattern registers in IDLE only; ignored elsewhere.
- Ack with stb=0 or cyc=0 is ignored. rty is never acted on.

## Timing
- cyc/stb rise one cycle after run=1 is sampled in IDLE.
- With ack held high: one block = BURST_LEN consecutive cyc=1 cycles, then 1 GAP cycle. Period is BURST_LEN+1 cycles.
- Slave wait states (ack=0): all outputs hold stable until ack.
- The last beat has cti=3'b111 in the same cycle as its ack.
- ov_block_cnt and GAP entry happen on the edge after the last ack.
- err seen at edge N: cyc=0 from edge N, and o_gen_err=1 from edge N.

## Configuration
- GEN_WB_BURST_STALL_EN defined: after every STALL_PERIOD accepted beats (excluding after the last beat), stb=0 for one cycle. During the stall, cyc, cti, data and addr hold. This exercises slave master-delay tolerance.
- Without the macro: stb stays 1 for the whole BURST state; STALL_PERIOD is unused.

## Test plan
- Counter mode, run=1, single=1, ack=stb: 512 beats with data 0..511, cti=001 ×511 then 111, ov_block_cnt=1, then IDLE.
- Continuous counter mode for 3 blocks: cyc low exactly 1 cycle between blocks; second block starts at data 512; ov_block_cnt=3.
- PRBS mode: the first four beats match the reference LFSR sequence from seed 64'h1; with ack stalled 5 cycles on beat 10, data holds stable.
- err pulse after beat 100: cyc=0 next edge, o_gen_err=1, ov_block_cnt unchanged. Clear → IDLE, then run resumes.
- i_rst_n asserted at beat 300: cyc/stb=0 immediately and all outputs return to reset values.
- With GEN_WB_BURST_STALL_EN and STALL_PERIOD=16: a 1-cycle stb gap with cyc=1 after every 16 accepts; a block takes 512+31 cycles with cyc high.
